// File: rtl/ir_rx_pkg.sv
// Shared types and timing helpers for the NEC IR receiver.
// Nominal durations are in microseconds. The helpers turn them into clock-cycle
// windows for a given clock frequency and tolerance.
package ir_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_L,
    S_LEAD_H,
    S_BIT_L,
    S_BIT_H,
    S_STOP,
    S_RPT
  } ir_state_t;

  localparam int LEAD_L_US = 9000;
  localparam int LEAD_H_US = 4500;
  localparam int RPT_H_US  = 2250;
  localparam int BURST_US  = 560;
  localparam int ONE_H_US  = 1690;

  // Nominal duration in clock cycles. The product is formed in 64 bits so that
  // multi-ms durations at high clock rates do not overflow.
  function automatic int us_to_cycles(input int us, input int clk_hz);
    longint v;
    v = longint'(us) * longint'(clk_hz) / 64'sd1_000_000;
    return int'(v);
  endfunction

  // Smallest accepted width, in cycles (inclusive).
  function automatic int win_min(input int us, input int clk_hz, input int tol_pct);
    return int'(longint'(us_to_cycles(us, clk_hz)) * longint'(100 - tol_pct) / 64'sd100);
  endfunction

  // Largest accepted width, in cycles (inclusive).
  function automatic int win_max(input int us, input int clk_hz, input int tol_pct);
    return int'(longint'(us_to_cycles(us, clk_hz)) * longint'(100 + tol_pct) / 64'sd100);
  endfunction

endpackage

// File: rtl/ir_rx_sync_edge.sv
// Two-flop synchroniser for the raw IR pin, followed by rise/fall edge pulses.
// The flops reset to 1 to match the idle-high line, so reset release gives no
// false edge.
module ir_rx_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Synchronise the pin and keep one extra delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = ~r_prev &  r_sync;
  assign o_fall =  r_prev & ~r_sync;

endmodule

// File: rtl/ir_nec_rx.sv
// NEC infrared frame receiver. It measures the width of each level and walks the
// leader / 32 data bits / stop burst sequence. It publishes the frame when the
// command checksum is good.
// Optional feature macro IR_REPEAT_EN: repeat codes re-signal the last good frame.
module ir_nec_rx
  import ir_rx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int TOL_PCT     = 25,
  parameter int CNT_W       = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_in,
  output logic [31:0] ir_data,
  output logic        ir_data_vld,
  output logic        ir_repeat,
  output logic        ir_err
);

  localparam logic [31:0] LEAD_L_MIN = 32'(win_min(LEAD_L_US, CLK_FREQ_HZ, TOL_PCT));
  localparam logic [31:0] LEAD_L_MAX = 32'(win_max(LEAD_L_US, CLK_FREQ_HZ, TOL_PCT));
  localparam logic [31:0] LEAD_H_MIN = 32'(win_min(LEAD_H_US, CLK_FREQ_HZ, TOL_PCT));
  localparam logic [31:0] LEAD_H_MAX = 32'(win_max(LEAD_H_US, CLK_FREQ_HZ, TOL_PCT));
  localparam logic [31:0] RPT_H_MIN  = 32'(win_min(RPT_H_US,  CLK_FREQ_HZ, TOL_PCT));
  localparam logic [31:0] RPT_H_MAX  = 32'(win_max(RPT_H_US,  CLK_FREQ_HZ, TOL_PCT));
  localparam logic [31:0] BURST_MIN  = 32'(win_min(BURST_US,  CLK_FREQ_HZ, TOL_PCT));
  localparam logic [31:0] BURST_MAX  = 32'(win_max(BURST_US,  CLK_FREQ_HZ, TOL_PCT));
  localparam logic [31:0] ONE_H_MIN  = 32'(win_min(ONE_H_US,  CLK_FREQ_HZ, TOL_PCT));
  localparam logic [31:0] ONE_H_MAX  = 32'(win_max(ONE_H_US,  CLK_FREQ_HZ, TOL_PCT));
  // The leader space may be either a data leader or a repeat leader.
  localparam logic [31:0] LEAD_H_TO  = (LEAD_H_MAX > RPT_H_MAX) ? LEAD_H_MAX : RPT_H_MAX;

  function automatic logic in_win(input logic [31:0] v, input logic [31:0] lo,
                                  input logic [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  ir_state_t        r_state;
  ir_state_t        w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      w_width;
  logic [31:0]      r_sh;
  logic [4:0]       r_bit_cnt;
  logic [31:0]      r_data;
  logic             r_vld;
  logic             r_err;
  logic             w_rise;
  logic             w_fall;
  logic             w_err_next;
  logic             w_vld_next;
  logic             w_shift;
  logic             w_bit;
  logic             w_clr_bits;
  logic             w_load;
`ifdef IR_REPEAT_EN
  logic             r_rpt;
  logic             r_have_frame;
  logic             w_rpt_next;
`endif

  ir_rx_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(ir_in),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // Width of the level that ends at the current edge. The counter restarts at
  // 0 on the edge, so the width in cycles is the count plus one.
  assign w_width = 32'(r_cnt) + 32'd1;

  // State register plus a level-width counter that saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_rise || w_fall)
        r_cnt <= '0;
      else if (!(&r_cnt))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // Next-state logic: checks each edge against its window and flags a level
  // that outlives every window of its state.
  always_comb begin
    w_state_next = r_state;
    w_err_next   = 1'b0;
    w_vld_next   = 1'b0;
    w_shift      = 1'b0;
    w_bit        = 1'b0;
    w_clr_bits   = 1'b0;
    w_load       = 1'b0;
`ifdef IR_REPEAT_EN
    w_rpt_next   = 1'b0;
`endif
    case (r_state)
      S_IDLE: if (w_fall) w_state_next = S_LEAD_L;
      S_LEAD_L: begin
        if (w_rise) begin
          if (in_win(w_width, LEAD_L_MIN, LEAD_L_MAX)) w_state_next = S_LEAD_H;
          else                                           w_err_next   = 1'b1;
        end else if (w_width > LEAD_L_MAX) w_err_next = 1'b1;
      end
      S_LEAD_H: begin
        if (w_fall) begin
          if (in_win(w_width, LEAD_H_MIN, LEAD_H_MAX)) begin
            w_state_next = S_BIT_L;
            w_clr_bits   = 1'b1;
          end else if (in_win(w_width, RPT_H_MIN, RPT_H_MAX)) w_state_next = S_RPT;
          else                                                w_err_next   = 1'b1;
        end else if (w_width > LEAD_H_TO) w_err_next = 1'b1;
      end
      S_BIT_L: begin
        if (w_rise) begin
          if (in_win(w_width, BURST_MIN, BURST_MAX)) w_state_next = S_BIT_H;
          else                                        w_err_next   = 1'b1;
        end else if (w_width > BURST_MAX) w_err_next = 1'b1;
      end
      S_BIT_H: begin
        if (w_fall) begin
          if (in_win(w_width, BURST_MIN, BURST_MAX)) w_shift = 1'b1;
          else if (in_win(w_width, ONE_H_MIN, ONE_H_MAX)) begin
            w_shift = 1'b1;
            w_bit   = 1'b1;
          end else w_err_next = 1'b1;
          if (w_shift) w_state_next = (r_bit_cnt == 5'd31) ? S_STOP : S_BIT_L;
        end else if (w_width > ONE_H_MAX) w_err_next = 1'b1;
      end
      S_STOP: begin
        if (w_rise) begin
          w_state_next = S_IDLE;
          if (in_win(w_width, BURST_MIN, BURST_MAX) && (r_sh[31:24] == ~r_sh[23:16])) begin
            w_load     = 1'b1;
            w_vld_next = 1'b1;
          end else w_err_next = 1'b1;
        end else if (w_width > BURST_MAX) w_err_next = 1'b1;
      end
      S_RPT: begin
        if (w_rise) begin
          w_state_next = S_IDLE;
          if (in_win(w_width, BURST_MIN, BURST_MAX)) begin
`ifdef IR_REPEAT_EN
            if (r_have_frame) begin
              w_vld_next = 1'b1;
              w_rpt_next = 1'b1;
            end
`endif
          end else w_err_next = 1'b1;
        end else if (w_width > BURST_MAX) w_err_next = 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (w_err_next) w_state_next = S_IDLE;
  end

  // Shift register, bit counter, published data and the one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh      <= '0;
      r_bit_cnt <= '0;
      r_data    <= '0;
      r_vld     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_vld <= w_vld_next;
      r_err <= w_err_next;
      if (w_clr_bits)   r_bit_cnt <= '0;
      else if (w_shift) r_bit_cnt <= r_bit_cnt + 1'b1;
      if (w_shift) r_sh <= {w_bit, r_sh[31:1]};
      if (w_load)  r_data <= r_sh;
    end
  end

`ifdef IR_REPEAT_EN
  // Remember that a good frame exists, and register the repeat pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rpt        <= 1'b0;
      r_have_frame <= 1'b0;
    end else begin
      r_rpt <= w_rpt_next;
      if (w_load) r_have_frame <= 1'b1;
    end
  end
  assign ir_repeat = r_rpt;
`else
  assign ir_repeat = 1'b0;
`endif

  assign ir_data     = r_data;
  assign ir_data_vld = r_vld;
  assign ir_err      = r_err;

endmodule
